// File: rtl/dcache_wt.sv
// Direct-mapped, write-through, no-write-allocate data cache with flip-flop storage.
// Read hits answer one cycle after the request; misses and all writes stall the core.
module dcache_wt #(
  parameter int LINES = 16,
  parameter int IDX_W = $clog2(LINES)
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [31:0]  cpu_addr,
  input  logic         cpu_re,
  input  logic [3:0]   cpu_we,
  input  logic [31:0]  cpu_din,
  output logic [31:0]  cpu_dout,
  output logic         stall,
  output logic         mem_req_valid,
  input  logic         mem_req_ready,
  output logic         mem_req_rw,
  output logic [27:0]  mem_req_addr,
  output logic [127:0] mem_req_data,
  output logic [15:0]  mem_req_mask,
  input  logic         mem_resp_valid,
  input  logic [127:0] mem_resp_data
);

  localparam int TAG_W = 28 - IDX_W;

  typedef enum logic [2:0] {IDLE, CHECK, FILL_REQ, FILL_WAIT, WR_REQ} state_t;
  state_t state;

  // Request registers: accepted request held for the CHECK stage and beyond
  logic [29:0]      req_addr_p1;
  logic [3:0]       req_we_p1;
  logic [31:0]      req_din_p1;
  logic             req_wr_p1;

  logic             valid_q [LINES];
  logic [TAG_W-1:0] tag_q   [LINES];
  logic [31:0]      data_q  [LINES][4];

  logic [1:0]       req_word;
  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic             hit;
  logic             accept;
  logic             unused_addr_bits;

  assign unused_addr_bits = ^cpu_addr[1:0];

  assign req_word = req_addr_p1[1:0];
  assign req_idx  = req_addr_p1[IDX_W+1:2];
  assign req_tag  = req_addr_p1[29:IDX_W+2];
  assign hit      = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

  always_comb begin
    stall = 1'b0;
    case (state)
      IDLE:                stall = 1'b0;
      CHECK:               stall = req_wr_p1 || !hit;
      FILL_REQ, FILL_WAIT: stall = 1'b1;
      WR_REQ:              stall = !mem_req_ready;
      default:             stall = 1'b0;
    endcase
  end

  assign accept = !stall && (cpu_re || (|cpu_we));

  assign mem_req_valid = (state == FILL_REQ) || (state == WR_REQ);
  assign mem_req_rw    = (state == WR_REQ);
  assign mem_req_addr  = req_addr_p1[29:2];
  assign mem_req_data  = {4{req_din_p1}};
  assign mem_req_mask  = mem_req_rw ? (16'(req_we_p1) << {req_word, 2'b00}) : 16'h0000;

  assign cpu_dout = data_q[req_idx][req_word];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      req_addr_p1 <= '0;
      req_we_p1   <= '0;
      req_din_p1  <= '0;
      req_wr_p1   <= 1'b0;
    end else if (accept) begin
      state       <= CHECK;
      req_addr_p1 <= cpu_addr[31:2];
      req_we_p1   <= cpu_we;
      req_din_p1  <= cpu_din;
      req_wr_p1   <= |cpu_we;
    end else if (!stall) begin
      state <= IDLE;
    end else begin
      case (state)
        CHECK:     state <= req_wr_p1 ? WR_REQ : FILL_REQ;
        FILL_REQ:  if (mem_req_ready) state <= FILL_WAIT;
        FILL_WAIT: if (mem_resp_valid) state <= CHECK;
        default:   state <= state;
      endcase
    end
  end

  // A fill returns to CHECK, so the same request then completes as a hit
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < LINES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        for (int w = 0; w < 4; w++) data_q[i][w] <= '0;
      end
    end else if (state == FILL_WAIT && mem_resp_valid) begin
      valid_q[req_idx] <= 1'b1;
      tag_q[req_idx]   <= req_tag;
      for (int w = 0; w < 4; w++) data_q[req_idx][w] <= mem_resp_data[32*w +: 32];
    end else if (state == CHECK && req_wr_p1 && hit) begin
      for (int b = 0; b < 4; b++)
        if (req_we_p1[b]) data_q[req_idx][req_word][8*b +: 8] <= req_din_p1[8*b +: 8];
    end
  end

endmodule

// File: tb/tb_dcache_wt.sv
// Scoreboard bench for dcache_wt: a behavioural memory answers requests and checks
// them against queued expectations; load data is checked against a word-level model.
module tb_dcache_wt;

  localparam int LINES = 16;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [31:0]  cpu_addr;
  logic         cpu_re;
  logic [3:0]   cpu_we;
  logic [31:0]  cpu_din;
  logic [31:0]  cpu_dout;
  logic         stall;
  logic         mem_req_valid;
  logic         mem_req_ready;
  logic         mem_req_rw;
  logic [27:0]  mem_req_addr;
  logic [127:0] mem_req_data;
  logic [15:0]  mem_req_mask;
  logic         mem_resp_valid;
  logic [127:0] mem_resp_data;

  dcache_wt #(.LINES(LINES)) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_addr(cpu_addr), .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout), .stall(stall),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_rw(mem_req_rw),
    .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data), .mem_req_mask(mem_req_mask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         rw;
    logic [27:0]  addr;
    logic [15:0]  mask;
    logic [127:0] data;
  } mreq_t;

  int n_checks = 0;
  int n_fail   = 0;

  mreq_t       mem_q[$];
  logic [31:0] rd_q[$];
  logic [31:0] mem_w [logic [29:0]];

  int ready_delay = 0;
  int resp_lat    = 3;

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [29:0] wa);
    if (wa == 30'h40) return 32'hCAFEF00D;
    return (32'(wa) * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic logic [31:0] mem_get(input logic [29:0] wa);
    if (mem_w.exists(wa)) return mem_w[wa];
    return init_word(wa);
  endfunction

  function automatic logic [127:0] line_of(input logic [27:0] la);
    logic [127:0] l;
    for (int w = 0; w < 4; w++) l[32*w +: 32] = mem_get({la, 2'(w)});
    return l;
  endfunction

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  // Behavioural memory: ready after ready_delay cycles, single-beat fill resp_lat cycles later
  int           wait_cnt = 0;
  int           resp_cnt = 0;
  logic         hs_prev  = 1'b0;
  logic         hs_rw;
  logic [27:0]  hs_addr;
  logic [15:0]  hs_mask;
  logic [127:0] hs_data;
  logic [27:0]  resp_line;
  logic         prev_rw;
  logic [27:0]  prev_addr;
  logic [15:0]  prev_mask;
  logic [127:0] prev_data;

  initial begin
    mreq_t e;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    forever begin
      @(posedge clk);
      #2;
      if (hs_prev) begin
        check_val("memq_nonempty", 128'(mem_q.size() != 0), 128'd1);
        if (mem_q.size() != 0) begin
          e = mem_q.pop_front();
          check_val("mem_rw", 128'(hs_rw), 128'(e.rw));
          check_val("mem_addr", 128'(hs_addr), 128'(e.addr));
          check_val("mem_mask", 128'(hs_mask), 128'(e.mask));
          if (e.rw) check_val("mem_data", hs_data, e.data);
        end
        if (!hs_rw) begin
          resp_cnt  = resp_lat;
          resp_line = hs_addr;
        end
      end
      mem_resp_valid = 1'b0;
      if (resp_cnt > 0) begin
        resp_cnt--;
        if (resp_cnt == 0) begin
          mem_resp_valid = 1'b1;
          mem_resp_data  = line_of(resp_line);
        end
      end
      if (mem_req_valid) begin
        if (wait_cnt > 0) begin
          check_val("req_stable_hdr", 128'({mem_req_rw, mem_req_addr, mem_req_mask}),
                    128'({prev_rw, prev_addr, prev_mask}));
          check_val("req_stable_data", mem_req_data, prev_data);
        end
        mem_req_ready = (wait_cnt >= ready_delay);
        wait_cnt++;
        prev_rw   = mem_req_rw;
        prev_addr = mem_req_addr;
        prev_mask = mem_req_mask;
        prev_data = mem_req_data;
      end else begin
        mem_req_ready = 1'b0;
        wait_cnt      = 0;
      end
      hs_prev = mem_req_valid && mem_req_ready;
      hs_rw   = mem_req_rw;
      hs_addr = mem_req_addr;
      hs_mask = mem_req_mask;
      hs_data = mem_req_data;
      if (hs_prev) wait_cnt = 0;
    end
  end

  // Issue a read when the cache is not stalling; exp_cycles is the expected stall length
  task automatic do_read(input logic [31:0] a, input int exp_cycles);
    int n;
    mreq_t e;
    logic [31:0] exp;
    cpu_addr = a;
    cpu_re   = 1'b1;
    cpu_we   = 4'h0;
    if (exp_cycles != 0) begin
      e = '{rw: 1'b0, addr: a[31:4], mask: 16'h0000, data: '0};
      mem_q.push_back(e);
    end
    rd_q.push_back(mem_get(a[31:2]));
    tick();
    cpu_re = 1'b0;
    check_val("rd_stall_first", 128'(stall), 128'(exp_cycles != 0));
    n = 0;
    while (stall && n < 50) begin
      tick();
      n++;
    end
    exp = rd_q.pop_front();
    if (stall) check_val("rd_timeout", 128'(stall), 128'd0);
    else begin
      check_val("rd_stall_cycles", 128'(n), 128'(exp_cycles));
      check_val("rd_data", 128'(cpu_dout), 128'(exp));
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [3:0] we, input logic [31:0] din,
                          input int delay);
    int n;
    mreq_t e;
    logic [31:0] w;
    logic [15:0] m;
    m = 16'(we) << (4 * a[3:2]);
    e = '{rw: 1'b1, addr: a[31:4], mask: m, data: {4{din}}};
    mem_q.push_back(e);
    w = mem_get(a[31:2]);
    for (int b = 0; b < 4; b++) if (we[b]) w[8*b +: 8] = din[8*b +: 8];
    mem_w[a[31:2]] = w;
    ready_delay = delay;
    cpu_addr = a;
    cpu_re   = 1'b0;
    cpu_we   = we;
    cpu_din  = din;
    tick();
    cpu_we = 4'h0;
    check_val("wr_stall_check", 128'(stall), 128'd1);
    n = 0;
    while (stall && n < 50) begin
      tick();
      n++;
    end
    if (stall) check_val("wr_timeout", 128'(stall), 128'd0);
    else check_val("wr_stall_cycles", 128'(n), 128'(1 + delay));
    ready_delay = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cpu_addr = '0;
    cpu_re   = 1'b0;
    cpu_we   = 4'h0;
    cpu_din  = '0;
    reset_n  = 1'b1;
    #1 reset_n = 1'b0;
    tick();
    tick();
    check_val("rst_stall", 128'(stall), 128'd0);
    check_val("rst_mem_valid", 128'(mem_req_valid), 128'd0);
    check_val("rst_dout", 128'(cpu_dout), 128'd0);
    reset_n = 1'b1;
    tick();

    // cold miss with a 3-cycle memory, then hit
    do_read(32'h0000_0100, 5);
    do_read(32'h0000_0100, 0);

    // write hit with partial byte enables, then read back the merged word
    do_write(32'h0000_0104, 4'b0011, 32'h0000_BEEF, 0);
    do_read(32'h0000_0104, 0);
    check_val("merge_explicit", 128'(cpu_dout),
              128'({init_word(30'h41) >> 16, 16'hBEEF}));

    // back-to-back hits
    do_read(32'h0000_0100, 0);
    do_read(32'h0000_0108, 0);

    // write miss with delayed ready: no allocation
    do_write(32'h0000_2000, 4'hF, 32'h1234_5678, 5);
    do_read(32'h0000_2000, 5);

    // conflict eviction
    do_read(32'h0000_0100, 5);
    do_read(32'h0000_0100 + LINES * 16, 5);
    do_read(32'h0000_0100, 5);

    // reset during FILL_WAIT, late response ignored
    resp_lat = 6;
    cpu_addr = 32'h0000_0300;
    cpu_re   = 1'b1;
    mem_q.push_back('{rw: 1'b0, addr: 28'h030, mask: 16'h0000, data: '0});
    tick();
    cpu_re = 1'b0;
    tick();
    tick();
    check_val("fw_stall", 128'(stall), 128'd1);
    reset_n = 1'b0;
    #1;
    check_val("abort_stall", 128'(stall), 128'd0);
    check_val("abort_mem_valid", 128'(mem_req_valid), 128'd0);
    check_val("abort_dout", 128'(cpu_dout), 128'd0);
    tick();
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    resp_lat = 3;
    do_read(32'h0000_0300, 5);
    do_read(32'h0000_0100, 5);

    for (int i = 0; i < 4; i++) tick();
    check_val("memq_empty", 128'(mem_q.size()), 128'd0);
    check_val("rdq_empty", 128'(rd_q.size()), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
